// File: rtl/vx_issue_sched_pkg.sv
// Shared types for the issue scheduler: per-warp fence state.
package vx_issue_sched_pkg;

    // RUN: warp may issue. DRAIN: fence taken, waiting for in-flight work to retire.
    typedef enum logic {
        WS_RUN   = 1'b0,
        WS_DRAIN = 1'b1
    } warp_state_e;

endpackage

// File: rtl/vx_issue_sched_if.sv
// Request/issue/commit/fence signal bundle between front end and scheduler.
interface vx_issue_sched_if #(
    parameter int NUM_WARPS  = 4,
    parameter int NW_WIDTH   = 2,
    parameter int DECR_COUNT = 2
);
    logic [NUM_WARPS-1:0]                  req_valid;
    logic [NUM_WARPS-1:0]                  req_fence;
    logic [NUM_WARPS-1:0]                  grant;
    logic                                  issue_valid;
    logic [NW_WIDTH-1:0]                   issue_wid;
    logic                                  issue_ready;
    logic [DECR_COUNT-1:0]                 commit_valid;
    logic [DECR_COUNT-1:0][NW_WIDTH-1:0]   commit_wid;
    logic                                  fence_done;
    logic [NW_WIDTH-1:0]                   fence_wid;
    logic                                  busy;

    modport master (
        output req_valid, req_fence, issue_ready, commit_valid, commit_wid,
        input  grant, issue_valid, issue_wid, fence_done, fence_wid, busy
    );

    modport slave (
        input  req_valid, req_fence, issue_ready, commit_valid, commit_wid,
        output grant, issue_valid, issue_wid, fence_done, fence_wid, busy
    );
endinterface

// File: rtl/vx_issue_sched_warp_credit.sv
// Per-warp in-flight counter: +1 on issue fire, -N for N matching commit ports.
module vx_warp_credit #(
    parameter int NW_WIDTH   = 2,
    parameter int DECR_COUNT = 2,
    parameter int CTR_WIDTH  = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NW_WIDTH-1:0]                 wid,
    input  logic                                fire,
    input  logic [DECR_COUNT-1:0]               commit_valid,
    input  logic [DECR_COUNT-1:0][NW_WIDTH-1:0] commit_wid,
    output logic [CTR_WIDTH-1:0]                count
);
    logic [CTR_WIDTH:0] dec;
    logic [CTR_WIDTH:0] sum;

    // Popcount of commit ports retiring an instruction of this warp.
    always_comb begin
        dec = '0;
        for (int p = 0; p < DECR_COUNT; p++) begin
            if (commit_valid[p] && commit_wid[p] == wid)
                dec = dec + 1'b1;
        end
    end

    assign sum = {1'b0, count} + {{CTR_WIDTH{1'b0}}, fire};

    // Net issue against retirement; an underflowing (illegal) commit leaves the counter at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (sum < dec)
            count <= '0;
        else
            count <= CTR_WIDTH'(sum - dec);
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(count == '0 && dec != '0));

endmodule

// File: rtl/vx_issue_sched.sv
// Round-robin warp issue arbiter with per-warp credit limits and fence draining.
module vx_issue_sched
    import vx_issue_sched_pkg::*;
#(
    parameter int NUM_WARPS   = 4,
    parameter int NW_WIDTH    = 2,
    parameter int DECR_COUNT  = 2,
    parameter int MAX_PENDING = 8,
    parameter int CTR_WIDTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    vx_issue_sched_if.slave   bus
);
    logic [NUM_WARPS-1:0][CTR_WIDTH-1:0] cnt;
    warp_state_e                         state_q [NUM_WARPS];
    logic [NW_WIDTH-1:0]                 last_grant;
    logic [NUM_WARPS-1:0]                eligible;
    logic [NUM_WARPS-1:0]                fire_vec;
    logic                                sel_found;
    logic [NW_WIDTH-1:0]                 sel_wid;
    logic                                sel_fence;
    logic                                fire;
    logic                                fence_grant;
    logic [NUM_WARPS-1:0]                sel_onehot;

    // Eligibility uses registered counts only; same-cycle commits do not open a slot.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++)
            eligible[w] = bus.req_valid[w] && (state_q[w] == WS_RUN) &&
                          (cnt[w] < CTR_WIDTH'(MAX_PENDING));
    end

    // Round-robin pick starting one past the last granted warp.
    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_wid   = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = (int'(last_grant) + 1 + i) % NUM_WARPS;
            if (!sel_found && eligible[idx]) begin
                sel_found = 1'b1;
                sel_wid   = NW_WIDTH'(idx);
            end
        end
    end

    assign sel_fence   = sel_found && bus.req_fence[sel_wid];
    assign sel_onehot  = NUM_WARPS'(1) << sel_wid;
    // Reset gating keeps request-driven outputs quiet while reset is held.
    assign bus.issue_valid = !reset && sel_found && !sel_fence;
    assign bus.issue_wid   = bus.issue_valid ? sel_wid : '0;
    assign fire            = bus.issue_valid && bus.issue_ready;
    assign fence_grant     = !reset && sel_fence;
    assign bus.grant       = (fire || fence_grant) ? sel_onehot : '0;
    assign fire_vec        = fire ? sel_onehot : '0;

    // One credit counter per warp.
    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        vx_warp_credit #(
            .NW_WIDTH   (NW_WIDTH),
            .DECR_COUNT (DECR_COUNT),
            .CTR_WIDTH  (CTR_WIDTH)
        ) u_credit (
            .clk          (clk),
            .reset        (reset),
            .wid          (NW_WIDTH'(w)),
            .fire         (fire_vec[w]),
            .commit_valid (bus.commit_valid),
            .commit_wid   (bus.commit_wid),
            .count        (cnt[w])
        );
    end

    // Fence completion: lowest-index drained warp wins; the rest wait a cycle.
    always_comb begin
        bus.fence_done = 1'b0;
        bus.fence_wid  = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (!bus.fence_done && state_q[w] == WS_DRAIN && cnt[w] == '0) begin
                bus.fence_done = 1'b1;
                bus.fence_wid  = NW_WIDTH'(w);
            end
        end
    end

    // Busy from registered state only.
    always_comb begin
        bus.busy = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++)
            if (cnt[w] != '0 || state_q[w] == WS_DRAIN)
                bus.busy = 1'b1;
    end

    // Fence FSM and round-robin pointer update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= NW_WIDTH'(NUM_WARPS - 1);
            for (int w = 0; w < NUM_WARPS; w++)
                state_q[w] <= WS_RUN;
        end else begin
            if (fire || fence_grant)
                last_grant <= sel_wid;
            if (fence_grant)
                state_q[sel_wid] <= WS_DRAIN;
            if (bus.fence_done)
                state_q[bus.fence_wid] <= WS_RUN;
        end
    end

endmodule

// File: tb/tb_vx_issue_sched.sv
// Directed bench for vx_issue_sched with hand-computed expectations.
module tb_vx_issue_sched;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    vx_issue_sched_if #(.NUM_WARPS(4), .NW_WIDTH(2), .DECR_COUNT(2)) bus ();

    vx_issue_sched #(
        .NUM_WARPS(4), .NW_WIDTH(2), .DECR_COUNT(2), .MAX_PENDING(8), .CTR_WIDTH(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Apply inputs at the falling edge, then settle before checking.
    task automatic drive(input logic [3:0] rv, input logic [3:0] rf, input logic rdy,
                         input logic [1:0] cv, input logic [1:0] cw0, input logic [1:0] cw1);
        @(negedge clk);
        bus.req_valid     = rv;
        bus.req_fence     = rf;
        bus.issue_ready   = rdy;
        bus.commit_valid  = cv;
        bus.commit_wid[0] = cw0;
        bus.commit_wid[1] = cw1;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = 4'b1111; bus.req_fence = 4'b0000; bus.issue_ready = 1'b1;
        bus.commit_valid = 2'b00; bus.commit_wid[0] = 2'd0; bus.commit_wid[1] = 2'd0;
        #1;
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_issue_valid", 32'(bus.issue_valid), 32'h0);
        chk("rst_fence_done", 32'(bus.fence_done), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bus.req_valid = 4'b0000;
        #1;
        chk("idle_issue_wid", 32'(bus.issue_wid), 32'h0);
        chk("idle_fence_wid", 32'(bus.fence_wid), 32'h0);
    endtask

    initial begin
        logic [1:0] rr_exp [5];
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.req_valid = '0; bus.req_fence = '0; bus.issue_ready = 1'b0;
        bus.commit_valid = '0; bus.commit_wid[0] = '0; bus.commit_wid[1] = '0;

        // Round-robin across all warps
        do_reset();
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 4'b0000, 1'b1, 2'b00, 2'd0, 2'd0);
            chk("rr_wid", 32'(bus.issue_wid), 32'(rr_exp[i]));
            chk("rr_grant", 32'(bus.grant), 32'(4'b0001 << rr_exp[i]));
        end
        drive(4'b0000, 4'b0000, 1'b1, 2'b00, 2'd0, 2'd0);
        chk("rr_busy", 32'(bus.busy), 32'h1);

        // Credit limit on warp 1
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(4'b0010, 4'b0000, 1'b1, 2'b00, 2'd0, 2'd0);
            chk("lim_fire", 32'({bus.issue_valid, bus.issue_wid, bus.grant}), 32'({1'b1, 2'd1, 4'b0010}));
        end
        drive(4'b0010, 4'b0000, 1'b1, 2'b01, 2'd1, 2'd0);
        chk("lim_full_valid", 32'(bus.issue_valid), 32'h0);
        chk("lim_full_grant", 32'(bus.grant), 32'h0);
        drive(4'b0010, 4'b0000, 1'b1, 2'b00, 2'd0, 2'd0);
        chk("lim_resume", 32'({bus.issue_valid, bus.grant}), 32'({1'b1, 4'b0010}));

        // Stalled downstream: no grant, pointer held, count held
        do_reset();
        drive(4'b0010, 4'b0000, 1'b1, 2'b00, 2'd0, 2'd0);
        chk("stall_pre_grant", 32'(bus.grant), 32'h2);
        drive(4'b1000, 4'b0000, 1'b0, 2'b00, 2'd0, 2'd0);
        chk("stall_offer", 32'({bus.issue_valid, bus.issue_wid}), 32'({1'b1, 2'd3}));
        chk("stall_grant", 32'(bus.grant), 32'h0);
        drive(4'b1111, 4'b0000, 1'b0, 2'b00, 2'd0, 2'd0);
        chk("stall_ptr", 32'(bus.issue_wid), 32'h2);
        drive(4'b1000, 4'b1000, 1'b0, 2'b00, 2'd0, 2'd0);
        chk("fence3_grant", 32'(bus.grant), 32'h8);
        chk("fence3_no_issue", 32'(bus.issue_valid), 32'h0);
        drive(4'b0000, 4'b0000, 1'b0, 2'b00, 2'd0, 2'd0);
        chk("fence3_done", 32'({bus.fence_done, bus.fence_wid}), 32'({1'b1, 2'd3}));
        drive(4'b0000, 4'b0000, 1'b0, 2'b00, 2'd0, 2'd0);
        chk("fence3_pulse", 32'(bus.fence_done), 32'h0);

        // Fence drain on warp 2 with three outstanding
        do_reset();
        for (int i = 0; i < 3; i++)
            drive(4'b0100, 4'b0000, 1'b1, 2'b00, 2'd0, 2'd0);
        drive(4'b0100, 4'b0100, 1'b1, 2'b00, 2'd0, 2'd0);
        chk("drain_fence_grant", 32'({bus.grant, bus.issue_valid}), 32'({4'b0100, 1'b0}));
        for (int i = 0; i < 3; i++) begin
            drive(4'b0100, 4'b0000, 1'b1, 2'b01, 2'd2, 2'd0);
            chk("drain_blocked", 32'({bus.grant, bus.fence_done}), 32'h0);
        end
        drive(4'b0100, 4'b0000, 1'b1, 2'b00, 2'd0, 2'd0);
        chk("drain_done", 32'({bus.fence_done, bus.fence_wid, bus.grant}), 32'({1'b1, 2'd2, 4'b0000}));
        drive(4'b0100, 4'b0000, 1'b1, 2'b00, 2'd0, 2'd0);
        chk("drain_after", 32'({bus.fence_done, bus.grant}), 32'({1'b0, 4'b0100}));

        // Fire plus two commits on the same warp in one cycle
        do_reset();
        drive(4'b0001, 4'b0000, 1'b1, 2'b00, 2'd0, 2'd0);
        drive(4'b0001, 4'b0000, 1'b1, 2'b00, 2'd0, 2'd0);
        drive(4'b0001, 4'b0000, 1'b1, 2'b11, 2'd0, 2'd0);
        chk("net_grant", 32'(bus.grant), 32'h1);
        drive(4'b0000, 4'b0000, 1'b1, 2'b01, 2'd0, 2'd0);
        chk("net_busy_one", 32'(bus.busy), 32'h1);
        drive(4'b0000, 4'b0000, 1'b1, 2'b00, 2'd0, 2'd0);
        chk("net_busy_zero", 32'(bus.busy), 32'h0);

        // Reset while warp 1 drains
        do_reset();
        drive(4'b0010, 4'b0000, 1'b1, 2'b00, 2'd0, 2'd0);
        drive(4'b0010, 4'b0010, 1'b1, 2'b00, 2'd0, 2'd0);
        chk("mid_fence_grant", 32'(bus.grant), 32'h2);
        drive(4'b1111, 4'b0000, 1'b1, 2'b00, 2'd0, 2'd0);
        chk("mid_busy", 32'(bus.busy), 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_rst_outs", 32'({bus.grant, bus.issue_valid, bus.fence_done, bus.busy}), 32'h0);
        drive(4'b0000, 4'b0000, 1'b1, 2'b00, 2'd0, 2'd0);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            drive(4'b0000, 4'b0000, 1'b1, 2'b00, 2'd0, 2'd0);
            chk("mid_no_done", 32'({bus.fence_done, bus.busy}), 32'h0);
        end
        drive(4'b0010, 4'b0000, 1'b1, 2'b00, 2'd0, 2'd0);
        chk("mid_run_again", 32'(bus.grant), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
